// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding APB4 initiator driven by a valid/ready
// command channel, returning read data and error status on a valid/ready
// response channel.
// Optional build macro: APB_CMD_MASTER_TIMEOUT_EN adds an ACCESS-phase
// watchdog that aborts a transfer after TIMEOUT cycles without PREADY.
module apb_cmd_master #(
    parameter int unsigned AW      = 13,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic          pclk,
    input  logic          resetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [31:0]   cmd_wdata,
    input  logic [3:0]    cmd_strb,
    input  logic [2:0]    cmd_prot,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_timeout,
    output logic          busy,
    output logic          PSEL,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [AW-1:0] PADDR,
    output logic [3:0]    PSTRB,
    output logic [2:0]    PPROT,
    output logic [31:0]   PWDATA,
    output logic          APBACTIVE,
    input  logic [31:0]   PRDATA,
    input  logic          PREADY,
    input  logic          PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;

    // Reject out-of-range watchdog limits at elaboration time.
    if (TIMEOUT < 2 || TIMEOUT > 65536) begin : g_timeout_range
        $error("apb_cmd_master: TIMEOUT must be in 2..65536");
    end

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT);
    logic [TW-1:0] wait_cnt;
`endif

    // Bus-active hint must see a new command before the FSM leaves IDLE.
    assign APBACTIVE = busy | cmd_valid;

    // Command FSM with all bus and response outputs registered.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'd0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PSTRB       <= 4'd0;
            PPROT       <= 3'd0;
            PWDATA      <= 32'd0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_addr[1:0] != 2'b00) begin
                            // Misaligned: answer with an error, no bus cycle.
                            state       <= RESP;
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_rdata   <= 32'd0;
                            rsp_timeout <= 1'b0;
                        end else begin
                            state   <= SETUP;
                            PSEL    <= 1'b1;
                            PENABLE <= 1'b0;
                            PWRITE  <= cmd_write;
                            PADDR   <= cmd_addr;
                            PWDATA  <= cmd_wdata;
                            PSTRB   <= cmd_write ? cmd_strb : 4'd0;
                            PPROT   <= cmd_prot;
                        end
                    end
                end

                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end

                ACCESS: begin
                    if (PREADY) begin
                        state       <= RESP;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        PWRITE      <= 1'b0;
                        PADDR       <= '0;
                        PSTRB       <= 4'd0;
                        PPROT       <= 3'd0;
                        PWDATA      <= 32'd0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= PWRITE ? 32'd0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                    end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                    else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        // Watchdog expired with the slave still stalling.
                        state       <= RESP;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        PWRITE      <= 1'b0;
                        PADDR       <= '0;
                        PSTRB       <= 4'd0;
                        PPROT       <= 3'd0;
                        PWDATA      <= 32'd0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= 32'd0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
`endif
                end

                RESP: begin
                    if (rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid   <= 1'b0;
                        rsp_rdata   <= 32'd0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        cmd_ready   <= 1'b1;
                        busy        <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master; the timeout scenario is compiled in
// when APB_CMD_MASTER_TIMEOUT_EN is defined (instance uses TIMEOUT = 8).
module tb_apb_cmd_master;

    localparam int unsigned AW = 13;

    logic          pclk = 1'b0;
    logic          resetn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_strb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
    logic [31:0]   rsp_rdata;
    logic          PSEL, PENABLE, PWRITE, APBACTIVE, PREADY, PSLVERR;
    logic [AW-1:0] PADDR;
    logic [3:0]    PSTRB;
    logic [2:0]    PPROT;
    logic [31:0]   PWDATA, PRDATA;

    int checks = 0;
    int errors = 0;

    apb_cmd_master #(.AW(AW), .TIMEOUT(8)) dut (
        .pclk(pclk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PSTRB(PSTRB), .PPROT(PPROT), .PWDATA(PWDATA), .APBACTIVE(APBACTIVE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Issues one command, plays an APB slave with the given wait count and
    // returns edges from the offer to rsp_valid; leaves the response pending.
    task automatic run_cmd(input logic wr, input logic [AW-1:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input int waits, input logic err_wait,
                           input logic err_ready, output int lat,
                           output logic saw_psel);
        int acc;
        acc = 0;
        lat = 0;
        saw_psel = 1'b0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
        cmd_wdata = wdata; cmd_strb = strb; cmd_prot = 3'd0;
        while (lat < 60) begin
            tick();
            lat++;
            cmd_valid = 1'b0;
            if (PSEL) saw_psel = 1'b1;
            if (rsp_valid) break;
            if (PSEL && PENABLE) begin
                PREADY  = (acc == waits);
                PSLVERR = PREADY ? err_ready : err_wait;
                acc++;
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'b0;
            end
        end
        PREADY = 1'b0;
        PSLVERR = 1'b0;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        tick();
        checks++;
        if ({cmd_ready, rsp_valid, busy, PSEL, PENABLE, APBACTIVE} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=100000",
                     {cmd_ready, rsp_valid, busy, PSEL, PENABLE, APBACTIVE});
        end
        checks++;
        if ({PADDR, PSTRB, PWDATA, rsp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data paddr=%h pstrb=%h pwdata=%h rdata=%h exp all 0",
                     PADDR, PSTRB, PWDATA, rsp_rdata);
        end
        cmd_valid = 1'b1;
        #1;
        checks++;
        if (APBACTIVE !== 1'b1) begin
            errors++;
            $display("FAIL apbactive_cmd got=%b exp=1", APBACTIVE);
        end
        cmd_valid = 1'b0;
        #1;
    endtask

    task automatic test_zero_wait_read();
        PREADY = 1'b1; PRDATA = 32'hDEADBEEF;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h010;
        cmd_strb = 4'hF; cmd_prot = 3'b010; cmd_wdata = 32'hAAAA5555;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PSTRB, PPROT, cmd_ready, busy} !==
            {1'b1, 1'b0, 1'b0, 13'h010, 4'h0, 3'b010, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rd_setup sel=%b en=%b wr=%b addr=%h strb=%h prot=%h rdy=%b busy=%b exp 1 0 0 010 0 2 0 1",
                     PSEL, PENABLE, PWRITE, PADDR, PSTRB, PPROT, cmd_ready, busy);
        end
        tick();
        checks++;
        if ({PSEL, PENABLE, PADDR, PSTRB, rsp_valid} !== {1'b1, 1'b1, 13'h010, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL rd_access sel=%b en=%b addr=%h strb=%h rv=%b exp 1 1 010 0 0",
                     PSEL, PENABLE, PADDR, PSTRB, rsp_valid);
        end
        tick();
        PREADY = 1'b0;
        checks++;
        if ({rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE} !==
            {1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rd_resp rv=%b rdata=%h err=%b sel=%b en=%b exp 1 deadbeef 0 0 0",
                     rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE);
        end
        take_rsp();
        checks++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL rd_done rv/rdy/busy got=%b exp=010", {rsp_valid, cmd_ready, busy});
        end
    endtask

    task automatic test_write_waits();
        int bad;
        bad = 0;
        PREADY = 1'b0; PRDATA = 32'hCAFEF00D;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 13'h024;
        cmd_wdata = 32'h12345678; cmd_strb = 4'h5; cmd_prot = 3'b001;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, rsp_valid} !==
                {1'b1, 1'b1, 1'b1, 13'h024, 32'h12345678, 4'h5, 3'b001, 1'b0}) bad++;
            if (i == 3) PREADY = 1'b1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wr_access_stable bad_cycles=%0d exp=0", bad);
        end
        tick();
        PREADY = 1'b0;
        checks++;
        if ({rsp_valid, rsp_rdata, rsp_err, PSEL, PSTRB, PWDATA} !==
            {1'b1, 32'd0, 1'b0, 1'b0, 4'h0, 32'd0}) begin
            errors++;
            $display("FAIL wr_resp rv=%b rdata=%h err=%b sel=%b strb=%h pwdata=%h exp 1 0 0 0 0 0",
                     rsp_valid, rsp_rdata, rsp_err, PSEL, PSTRB, PWDATA);
        end
        take_rsp();
    endtask

    task automatic test_slave_error();
        int lat;
        logic saw;
        PRDATA = 32'h0000BEEF;
        run_cmd(1'b0, 13'h040, 32'd0, 4'h0, 2, 1'b0, 1'b1, lat, saw);
        checks++;
        if ({rsp_valid, rsp_err, lat} !== {1'b1, 1'b1, 32'd5}) begin
            errors++;
            $display("FAIL slverr_ready rv=%b err=%b lat=%0d exp 1 1 5", rsp_valid, rsp_err, lat);
        end
        take_rsp();
        run_cmd(1'b0, 13'h044, 32'd0, 4'h0, 1, 1'b1, 1'b0, lat, saw);
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0000BEEF}) begin
            errors++;
            $display("FAIL slverr_wait_ignored rv=%b err=%b rdata=%h exp 1 0 0000beef",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        take_rsp();
    endtask

    task automatic test_misaligned();
        int lat;
        logic saw;
        run_cmd(1'b1, 13'h013, 32'h11112222, 4'hF, 0, 1'b0, 1'b0, lat, saw);
        checks++;
        if ({lat, saw, rsp_valid, rsp_err, rsp_rdata, PADDR} !==
            {32'd1, 1'b0, 1'b1, 1'b1, 32'd0, 13'd0}) begin
            errors++;
            $display("FAIL misaligned lat=%0d psel_seen=%b rv=%b err=%b rdata=%h paddr=%h exp 1 0 1 1 0 0",
                     lat, saw, rsp_valid, rsp_err, rsp_rdata, PADDR);
        end
        take_rsp();
    endtask

    task automatic test_backpressure_reset();
        int lat, bad;
        logic saw;
        bad = 0;
        PRDATA = 32'h5A5A0001;
        run_cmd(1'b0, 13'h100, 32'd0, 4'h0, 0, 1'b0, 1'b0, lat, saw);
        PRDATA = 32'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if ({rsp_valid, rsp_rdata, rsp_err, cmd_ready, PSEL} !==
                {1'b1, 32'h5A5A0001, 1'b0, 1'b0, 1'b0}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold bad_cycles=%0d exp=0", bad);
        end
        take_rsp();
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL backpressure_release rv/rdy got=%b exp=01", {rsp_valid, cmd_ready});
        end
        // Start a stalled read and reset it mid-ACCESS.
        PREADY = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h200;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({PSEL, PENABLE} !== 2'b11) begin
            errors++;
            $display("FAIL rst_pre_access sel/en got=%b exp=11", {PSEL, PENABLE});
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({PSEL, PENABLE, cmd_ready, busy} !== 4'b0010) begin
            errors++;
            $display("FAIL rst_async sel/en/rdy/busy got=%b exp=0010", {PSEL, PENABLE, cmd_ready, busy});
        end
        tick();
        resetn = 1'b1;
        tick();
        checks++;
        if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b0010) begin
            errors++;
            $display("FAIL rst_release sel/en/rdy/rv got=%b exp=0010", {PSEL, PENABLE, cmd_ready, rsp_valid});
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] got, exp;
        exp = 9'b100010001;
        got = '0;
        PREADY = 1'b1; rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 13'h008;
        cmd_wdata = 32'h0; cmd_strb = 4'hF;
        for (int i = 0; i < 9; i++) begin
            got[8-i] = cmd_ready;
            if (i == 8) cmd_valid = 1'b0;
            else tick();
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL back_to_back cmd_ready pattern got=%b exp=%b", got, exp);
        end
        tick(); tick(); tick(); tick();
        PREADY = 1'b0; rsp_ready = 1'b0;
        checks++;
        if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL back_to_back_idle rdy/busy/rv got=%b exp=100", {cmd_ready, busy, rsp_valid});
        end
    endtask

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int lat;
        logic saw;
        PRDATA = 32'h77778888;
        run_cmd(1'b0, 13'h300, 32'd0, 4'h0, 1000, 1'b0, 1'b0, lat, saw);
        checks++;
        if ({lat, rsp_valid, rsp_err, rsp_timeout, rsp_rdata, PSEL} !==
            {32'd10, 1'b1, 1'b1, 1'b1, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL timeout_abort lat=%0d rv=%b err=%b to=%b rdata=%h sel=%b exp 10 1 1 1 0 0",
                     lat, rsp_valid, rsp_err, rsp_timeout, rsp_rdata, PSEL);
        end
        take_rsp();
        run_cmd(1'b0, 13'h304, 32'd0, 4'h0, 7, 1'b0, 1'b0, lat, saw);
        checks++;
        if ({lat, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !==
            {32'd10, 1'b1, 1'b0, 1'b0, 32'h77778888}) begin
            errors++;
            $display("FAIL timeout_edge_ok lat=%0d rv=%b err=%b to=%b rdata=%h exp 10 1 0 0 77778888",
                     lat, rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
        end
        take_rsp();
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait_read();
        test_write_waits();
        test_slave_error();
        test_misaligned();
        test_backpressure_reset();
        test_back_to_back();
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
